// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetcher: keeps a small byte FIFO filled from instruction memory
// and presents the next four bytes (big-endian window) to decode, with redirect/flush.
module prefetch_queue #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_eip,
  output logic        ope_valid,
  output logic [31:0] ope,
  output logic [31:0] ope_eip,
  input  logic        consume,
  input  logic [2:0]  consume_len
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] h1;
  logic [PTR_W-1:0] h2;
  logic [PTR_W-1:0] h3;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] pop_len;
  logic             pending;
  logic             discard;
  logic [31:0]      fetch_eip;
  logic             issue;
  logic             retire;
  logic             push;
  logic             pop;

  always_comb begin
    issue      = !pending && !redirect && (count < CNT_W'(DEPTH));
    retire     = pending && mem_valid;
    push       = retire && !discard && !redirect;
    pop        = consume && ope_valid && !redirect &&
                 (consume_len >= 3'd1) && (consume_len <= 3'd4);
    pop_len    = pop ? CNT_W'(consume_len) : '0;
    count_next = count + CNT_W'(push) - pop_len;
  end

  // A request issued while the queue had room always has a slot when its byte returns,
  // so push never needs to check for full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      pending   <= 1'b0;
      discard   <= 1'b0;
      fetch_eip <= RESET_EIP;
      ope_eip   <= RESET_EIP;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      ope_valid <= 1'b0;
    end else if (redirect) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      fetch_eip <= redirect_eip;
      ope_eip   <= redirect_eip;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      ope_valid <= 1'b0;
      // A response landing this very cycle retires the old request; otherwise drop the next one.
      pending   <= pending && !mem_valid;
      discard   <= pending && !mem_valid;
    end else begin
      mem_rd    <= issue;
      mem_addr  <= issue ? fetch_eip : '0;
      if (issue) begin
        fetch_eip <= fetch_eip + 32'd1;
        pending   <= 1'b1;
      end else if (retire) begin
        pending <= 1'b0;
        discard <= 1'b0;
      end
      if (push) tail <= tail + PTR_W'(1);
      if (pop) begin
        head    <= head + PTR_W'(consume_len);
        ope_eip <= ope_eip + 32'(consume_len);
      end
      count     <= count_next;
      ope_valid <= (count_next >= CNT_W'(4));
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= mem_rdata;
  end

  always_comb begin
    h1  = head + PTR_W'(1);
    h2  = head + PTR_W'(2);
    h3  = head + PTR_W'(3);
    ope = ope_valid ? {q[head], q[h1], q[h2], q[h3]} : 32'h0;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus random traffic, checked every cycle
// against a queue-based behavioural model and a few hand-computed literals.
module tb_prefetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redirect = 1'b0;
  logic [31:0] redirect_eip = 32'h0;
  logic        ope_valid;
  logic [31:0] ope;
  logic [31:0] ope_eip;
  logic        consume = 1'b0;
  logic [2:0]  consume_len = 3'd0;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_EIP(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_eip(redirect_eip), .ope_valid(ope_valid), .ope(ope), .ope_eip(ope_eip),
    .consume(consume), .consume_len(consume_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;
  bit spur_en = 1'b0;

  // Behavioural model state
  logic [7:0]  q_m[$];
  bit          m_pending;
  bit          m_discard;
  bit          m_rd;
  logic [31:0] m_addr;
  logic [31:0] m_fetch;
  logic [31:0] m_eip;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h8B;
      32'd1:   return 8'h5D;
      32'd2:   return 8'h08;
      32'd3:   return 8'h90;
      32'd4:   return 8'hC3;
      default: return a[7:0] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    m_pending = 1'b0;
    m_discard = 1'b0;
    m_rd      = 1'b0;
    m_addr    = 32'h0;
    m_fetch   = 32'h0;
    m_eip     = 32'h0;
  endtask

  task automatic model_step();
    int  n;
    bit  retire;
    bit  issue;
    n      = q_m.size();
    retire = m_pending && mem_valid;
    if (redirect) begin
      q_m.delete();
      m_eip     = redirect_eip;
      m_fetch   = redirect_eip;
      m_discard = m_pending && !mem_valid;
      m_pending = m_discard;
      m_rd      = 1'b0;
      m_addr    = 32'h0;
    end else begin
      issue = !m_pending && (n < DEPTH);
      if (retire && !m_discard) q_m.push_back(mem_rdata);
      if (consume && n >= 4 && consume_len >= 3'd1 && consume_len <= 3'd4) begin
        for (int i = 0; i < int'(consume_len); i++) void'(q_m.pop_front());
        m_eip = m_eip + 32'(consume_len);
      end
      if (retire) begin
        m_pending = 1'b0;
        m_discard = 1'b0;
      end
      m_rd = issue;
      if (issue) begin
        m_addr    = m_fetch;
        m_fetch   = m_fetch + 32'd1;
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_ope;
    exp_ope = 32'h0;
    if (q_m.size() >= 4) exp_ope = {q_m[0], q_m[1], q_m[2], q_m[3]};
    chk("ope_valid", 32'(ope_valid), 32'(q_m.size() >= 4));
    chk("ope", ope, exp_ope);
    chk("ope_eip", ope_eip, m_eip);
    chk("mem_rd", 32'(mem_rd), 32'(m_rd));
    if (m_rd) chk("mem_addr", mem_addr, m_addr);
  endtask

  // One clock: model advances on the edge, outputs are compared and memory/inputs are
  // driven on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    compare_outputs();
    redirect    = 1'b0;
    consume     = 1'b0;
    consume_len = 3'd0;
    mem_valid   = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_valid = 1'b1;
        mem_rdata = mem_byte(resp_addr);
      end
    end
    if (mem_rd) begin
      resp_cnt  = lat;
      resp_addr = mem_addr;
    end
    if (spur_en && resp_cnt == 0 && !mem_rd && !mem_valid && $urandom_range(7) == 0) begin
      mem_valid = 1'b1;
      mem_rdata = 8'($urandom);
    end
  endtask

  task automatic wait_ope(input string name, input int limit, output int n);
    n = 0;
    while (!ope_valid && n < limit) begin
      cyc();
      n++;
    end
    chk(name, 32'(ope_valid), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    int rd_seen;
    logic [31:0] saved;
    logic [31:0] addrs [4];

    model_reset();
    #1;
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_ope_valid", 32'(ope_valid), 32'd0);
    chk("reset_ope", ope, 32'd0);
    chk("reset_ope_eip", ope_eip, 32'd0);
    repeat (3) cyc();
    reset = 1'b1;

    // Fill from reset, latency 1
    lat = 1;
    wait_ope("t1_ope_valid", 200, n);
    chk("t1_latency_ok", 32'(n >= 8), 32'd1);
    chk("t1_ope", ope, 32'h8B5D0890);
    chk("t1_ope_eip", ope_eip, 32'd0);

    // Pop three bytes, then illegal lengths
    consume = 1'b1; consume_len = 3'd3;
    cyc();
    chk("t2_ope_eip", ope_eip, 32'd3);
    wait_ope("t2_ope_valid", 200, n);
    chk("t2_ope_hi", 32'(ope[31:16]), 32'h90C3);
    saved = ope;
    consume = 1'b1; consume_len = 3'd0;
    cyc();
    chk("t2_len0_eip", ope_eip, 32'd3);
    chk("t2_len0_ope", ope, saved);
    consume = 1'b1; consume_len = 3'd5;
    cyc();
    chk("t2_len5_eip", ope_eip, 32'd3);
    chk("t2_len5_ope", ope, saved);

    // Fill to full, no requests while full, resume after pop
    repeat (60) cyc();
    rd_seen = 0;
    repeat (10) begin
      cyc();
      if (mem_rd) rd_seen++;
    end
    chk("t3_full_no_rd", 32'(rd_seen), 32'd0);
    consume = 1'b1; consume_len = 3'd4;
    cyc();
    n = 0;
    while (!mem_rd && n < 20) begin
      cyc();
      n++;
    end
    chk("t3_resume_rd", 32'(mem_rd), 32'd1);
    chk("t3_resume_addr", mem_addr, 32'd11);

    // Redirect while a slow request is in flight
    lat = 5;
    cyc();
    n = 0;
    while (!mem_rd && n < 50) begin
      cyc();
      n++;
    end
    chk("t4_req_seen", 32'(mem_rd), 32'd1);
    redirect = 1'b1; redirect_eip = 32'h40;
    cyc();
    wait_ope("t4_ope_valid", 300, n);
    chk("t4_ope", ope, 32'h1A1B1819);
    chk("t4_ope_eip", ope_eip, 32'h40);

    // Address wrap at 2^32
    lat = 1;
    redirect = 1'b1; redirect_eip = 32'hFFFF_FFFE;
    cyc();
    k = 0;
    n = 0;
    while (k < 4 && n < 100) begin
      cyc();
      if (mem_rd) begin
        addrs[k] = mem_addr;
        k++;
      end
      n++;
    end
    chk("t5_req_count", 32'(k), 32'd4);
    chk("t5_addr0", addrs[0], 32'hFFFF_FFFE);
    chk("t5_addr1", addrs[1], 32'hFFFF_FFFF);
    chk("t5_addr2", addrs[2], 32'h0000_0000);
    chk("t5_addr3", addrs[3], 32'h0000_0001);
    wait_ope("t5_ope_valid", 200, n);
    chk("t5_ope", ope, 32'h5B5A8B5D);
    chk("t5_ope_eip", ope_eip, 32'hFFFF_FFFE);
    consume = 1'b1; consume_len = 3'd2;
    cyc();
    chk("t5_eip_wrap", ope_eip, 32'h0);

    // Reset mid-fill with a request pending; its late response must be ignored
    lat = 5;
    cyc();
    n = 0;
    while (!mem_rd && n < 50) begin
      cyc();
      n++;
    end
    chk("t6_req_seen", 32'(mem_rd), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_mem_rd", 32'(mem_rd), 32'd0);
    chk("t6_ope_valid", 32'(ope_valid), 32'd0);
    chk("t6_ope", ope, 32'd0);
    repeat (8) cyc();
    reset = 1'b1;
    lat = 1;
    wait_ope("t6_ope_valid_after", 200, n);
    chk("t6_ope_after", ope, 32'h8B5D0890);
    chk("t6_ope_eip_after", ope_eip, 32'd0);

    // Random traffic against the model
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) lat = int'($urandom_range(4, 1));
      if ($urandom_range(63) == 0) begin
        redirect = 1'b1;
        redirect_eip = ($urandom_range(1) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3)))
                                                : 32'($urandom);
      end
      if ($urandom_range(1) == 1) begin
        consume = 1'b1;
        consume_len = 3'($urandom_range(5));
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
